distributed_sync_fifo: RTL and testbench

DISTRIBUTED_SYNC_FIFO -- requirements
Module: distributed_sync_fifo

---
 rtl/distributed_sync_fifo.sv | 106 ++++++++++
 tb/tb_distributed_sync_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/distributed_sync_fifo.sv
// rtl/distributed_sync_fifo.sv - single-clock FIFO on distributed RAM, standard or FWFT read
module distributed_sync_fifo #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FWFT       = 0,
   parameter int AFULL_TH   = (2**ADDR_WIDTH) - 2,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                  wr_clk,
   input  logic                  asyn_rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  rd_accept;
   logic                  wr_accept;

   // A write into a full FIFO is still legal when the head is leaving in the same cycle.
   assign rd_accept = rd_en & ~empty;
   assign wr_accept = wr_en & (~full | rd_accept);

   // Occupancy after this edge; the status flags are registered from it so they line up with count.
   always_comb begin
      count_next = count;
      if (wr_accept && !rd_accept) begin
         count_next = count + 1'b1;
      end else if (rd_accept && !wr_accept) begin
         count_next = count - 1'b1;
      end
   end

   // Storage: synchronous write, no reset; contents are only visible through the pointers.
   always_ff @(posedge wr_clk) begin
      if (wr_accept && !asyn_rst) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   // Pointers, occupancy, status flags and rejection pulses.
   always_ff @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count        <= count_next;
         full         <= (count_next == DEPTH_C);
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= AFULL_C);
         almost_empty <= (count_next <= AEMPTY_C);
         overflow     <= wr_en & ~wr_accept;
         underflow    <= rd_en & empty;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented combinationally; rd_en only pops it.
         assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_q;

         // Registered read: the head is captured on the accepting edge and held otherwise.
         always_ff @(posedge wr_clk or posedge asyn_rst) begin
            if (asyn_rst) begin
               rd_q <= '0;
            end else if (rd_accept) begin
               rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
         end

         assign rd_data = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_distributed_sync_fifo.sv
// tb/tb_distributed_sync_fifo.sv - directed bench for distributed_sync_fifo in both read modes
module tb_distributed_sync_fifo;

   logic       wr_clk = 1'b0;
   logic       asyn_rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;

   logic [7:0] s_rd_data, f_rd_data;
   logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
   logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
   logic [4:0] s_count, f_count;

   int total = 0;
   int bad   = 0;

   always #5 wr_clk = ~wr_clk;

   distributed_sync_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0)) u_std (
      .wr_clk(wr_clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(s_rd_data), .full(s_full), .empty(s_empty),
      .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf)
   );

   distributed_sync_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
      .wr_clk(wr_clk), .asyn_rst(asyn_rst), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(f_rd_data), .full(f_full), .empty(f_empty),
      .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   initial begin
      asyn_rst = 1'b1;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      rd_en    = 1'b0;
      tick();
      tick();
      check("rst_count", s_count, 0);
      check("rst_empty", s_empty, 1);
      check("rst_aempty", s_aempty, 1);
      check("rst_full", s_full, 0);
      check("rst_afull", s_afull, 0);
      check("rst_ovf", s_ovf, 0);
      check("rst_unf", s_unf, 0);
      check("rst_rd_data", s_rd_data, 0);
      check("rst_fwft_empty", f_empty, 1);
      asyn_rst = 1'b0;

      // Fill with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(i);
         tick();
         check("fill_count", s_count, i);
         check("fill_afull", s_afull, (i >= 14) ? 1 : 0);
         check("fill_full", s_full, (i == 16) ? 1 : 0);
         check("fill_aempty", s_aempty, (i <= 2) ? 1 : 0);
         check("fill_empty", s_empty, 0);
         check("fill_fwft_head", f_rd_data, 8'h01);
      end
      wr_data = 8'hAA;
      tick();
      check("ovf_pulse", s_ovf, 1);
      check("ovf_count", s_count, 16);
      check("ovf_fwft_count", f_count, 16);
      wr_en = 1'b0;
      tick();
      check("ovf_clear", s_ovf, 0);

      // Drain: standard data one cycle after rd_en, FWFT head before the pop
      for (int i = 1; i <= 16; i++) begin
         rd_en = 1'b1;
         check("drain_fwft", f_rd_data, i);
         tick();
         check("drain_std", s_rd_data, i);
         check("drain_count", s_count, 16 - i);
      end
      check("drain_empty", s_empty, 1);
      check("drain_fwft_empty", f_empty, 1);
      tick();
      check("unf_pulse", s_unf, 1);
      check("unf_hold", s_rd_data, 8'h10);
      check("unf_count", s_count, 0);
      rd_en = 1'b0;
      tick();
      check("unf_clear", s_unf, 0);

      // Empty with simultaneous write and read
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'h3C;
      tick();
      check("er_unf", s_unf, 1);
      check("er_count", s_count, 1);
      check("er_hold", s_rd_data, 8'h10);
      check("er_fwft", f_rd_data, 8'h3C);
      wr_en = 1'b0;
      tick();
      check("er_read", s_rd_data, 8'h3C);
      check("er_empty", s_empty, 1);
      rd_en = 1'b0;

      // FWFT single word visible right after its write edge
      wr_en = 1'b1;
      wr_data = 8'h5A;
      tick();
      check("fw_data", f_rd_data, 8'h5A);
      check("fw_empty", f_empty, 0);
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      check("fw_pop_empty", f_empty, 1);
      check("fw_pop_count", f_count, 0);
      rd_en = 1'b0;

      // Full with simultaneous write and read, across pointer wrap
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(i);
         tick();
      end
      check("fr_full", s_full, 1);
      wr_data = 8'h77;
      rd_en = 1'b1;
      check("fr_fwft_head", f_rd_data, 8'h01);
      tick();
      check("fr_read", s_rd_data, 8'h01);
      check("fr_count", s_count, 16);
      check("fr_full2", s_full, 1);
      check("fr_ovf", s_ovf, 0);
      wr_en = 1'b0;
      for (int i = 2; i <= 17; i++) begin
         tick();
         check("fr_drain", s_rd_data, (i == 17) ? 8'h77 : 8'(i));
      end
      check("fr_empty", s_empty, 1);
      rd_en = 1'b0;

      // Asynchronous reset with 9 words stored
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(8'h40 + i);
         tick();
      end
      wr_en = 1'b0;
      check("ar_count9", s_count, 9);
      #2 asyn_rst = 1'b1;
      #1;
      check("ar_count", s_count, 0);
      check("ar_empty", s_empty, 1);
      check("ar_fwft_count", f_count, 0);
      check("ar_rd_data", s_rd_data, 0);
      #2 asyn_rst = 1'b0;
      wr_en = 1'b1;
      wr_data = 8'h33;
      tick();
      check("ar_wr_count", s_count, 1);
      check("ar_fwft", f_rd_data, 8'h33);
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      check("ar_read", s_rd_data, 8'h33);
      check("ar_final_count", s_count, 0);
      rd_en = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
